sized_data_memory: RTL and testbench
====================================

// Module: sized_data_memory
// PURPOSE
//   Clocked, parametrised data memory for the CPU datapath MEM stage. It replaces the
//   combinational word-only store with sized loads and stores: byte, half and word, with
//   sign or zero extension. Read latency is one cycle, alignment and range are checked,
//   and a hardware zero-fill sequence runs after every reset.
// PARAMETERS
//   DATA_W   32   word width in bits; legal values are 32 or 64
//   DEPTH    32   number of words; power of two, >= 2
//   ADDR_W   32   byte-address width
// PORTS
//   clk          in   1        single clock; all state updates on the rising edge
//   reset        in   1        synchronous, active-high reset
//   addr         in   ADDR_W   byte address
//   mem_read     in   1        load request; sampled only while ready=1
//   mem_write    in   1        store request; sampled only while ready=1
//   size         in   2        00 byte, 01 half, 10 word(32), 11 dword (only when DATA_W=64)
//   ld_unsigned  in   1        1 = zero-extend loads; 0 = sign-extend loads
//   write_data   in   DATA_W   store data, taken from the low-order bytes
//   ready        out  1        1 = accepting requests (RUN state)
//   read_data    out  DATA_W   extended load result; valid when read_valid=1
//   read_valid   out  1        one-cycle pulse, the cycle after an accepted load
//   fault        out  1        one-cycle pulse, the cycle after a misaligned or out-of-range request
// BEHAVIOUR
//   - Word index = addr >> log2(DATA_W/8). Byte offset = the low address bits.
//   - Reset state: ready=0, read_data=0, read_valid=0, fault=0, FSM=INIT, init counter=0.
//   - INIT state:
//       - Writes zero to word [counter] each cycle and increments the counter.
//       - After word DEPTH-1 it moves to RUN.
//       - Takes exactly DEPTH cycles after reset deasserts.
//       - reset asserted during INIT restarts the sequence at counter 0.
//   - RUN state:
//       - ready=1 and requests are accepted.
//       - There is no other exit; only reset returns the FSM to INIT.
//   - Requests while ready=0 are ignored: no write, no read_valid, no fault.
//   - Alignment: half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
//     size=11 with DATA_W=32 counts as misaligned.
//   - Range: word index >= DEPTH is out of range.
//   - Faulting request:
//       - The store is dropped.
//       - A load returns read_data=0 with read_valid=1.
//       - fault=1 on the next cycle.
//   - Store: only the addressed byte lanes change, using a byte mask from size and offset.
//     The new contents are visible to loads on the next cycle.
//   - Load:
//       - Lanes are extracted at the offset and extended according to ld_unsigned.
//       - Result is registered: read_data and read_valid appear on cycle N+1 for a
//         request on cycle N.
//       - read_data holds its value until the next accepted load.
//   - Simultaneous mem_read and mem_write to the same word: both are performed. The load
//     returns the pre-store contents (read-first), unless the macro below is defined.
//   - Back-to-back requests every cycle are supported; there are no bubbles.
//   - reset in RUN: memory contents are re-zeroed through INIT; outputs return to reset values.
// CONFIGURATION
//   DMEM_WRITE_BYPASS_EN
//     defined:   a same-cycle load and store to the same word returns the merged
//                post-store word (write-first). Other timing is unchanged.
//     undefined: read-first, as described under BEHAVIOUR.
// STRUCTURE
//   - Package dmem_pkg:
//       - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D).
//       - state_e enum (ST_INIT, ST_RUN).
//       - Function byte_mask(size, offset).
//   - Sub-module dmem_lane_align (combinational):
//       - Store side: write-lane shifting and byte mask.
//       - Load side: lane extraction and sign/zero extension.
//       - Misalignment detection.
//   - Top level: storage array, FSM, init counter, output registers.
// TESTING
//   1. Release reset -> ready=0 for exactly 32 cycles, then 1. Every word reads back 0x00000000.
//   2. sw 0x8000_00FF @0x10; then lb @0x10 -> 0xFFFFFFFF; lbu @0x10 -> 0x000000FF;
//      lh @0x12 -> 0xFFFF8000. Each result appears one cycle after its request.
//   3. lw @0x06 -> read_data=0, read_valid=1, fault=1. sh @0x05 -> memory unchanged, fault=1.
//   4. sw @0x80 (index 32, out of range) -> fault=1 and no word modified.
//   5. Word @0x20 = 0x11223344. Same cycle: lw @0x20 and sb 0xAA @0x20 -> 0x11223344
//      (bypass off) or 0x112233AA (DMEM_WRITE_BYPASS_EN defined). Next lw -> 0x112233AA.
//   6. Pulse reset midway through INIT and in RUN -> INIT restarts at 0 and takes 32 cycles;
//      previously written data reads back 0.

Source files
------------

// File: rtl/sized_data_memory_pkg.sv
// Shared types and helpers for the sized data memory.
// Purely declarative: no timing of its own.
// Used by the lane aligner and the top level.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Byte-lane enable for an access of the given size at the given byte offset.
    // The mask is sized for the widest (64-bit) word; callers keep the low lanes.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size_e'(size))
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/sized_data_memory_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Responses arrive one cycle after an accepted request.
// ready=0 means requests are ignored, not queued.
interface sized_data_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              ld_unsigned;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              fault;

    modport master (
        output addr, mem_read, mem_write, size, ld_unsigned, write_data,
        input  ready, read_data, read_valid, fault
    );

    modport slave (
        input  addr, mem_read, mem_write, size, ld_unsigned, write_data,
        output ready, read_data, read_valid, fault
    );
endinterface

// File: rtl/sized_data_memory_lane_align.sv
// Byte-lane steering: store shift + byte mask, load extract + extend, alignment check.
// Latency: combinational.
// No flow control of its own.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic              ld_unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rword_i,
    output logic [DATA_W-1:0] wdata_sh_o,
    output logic [NB-1:0]     wmask_o,
    output logic              misaligned_o,
    output logic [DATA_W-1:0] ld_data_o
);
    logic [2:0] off3;
    logic [7:0] mask8;

    assign off3  = 3'(off_i);
    assign mask8 = byte_mask(size_i, off3);

    // Store side: move the low-order store bytes up to the addressed lanes.
    always_comb begin
        wdata_sh_o = wdata_i << {off_i, 3'b000};
        wmask_o    = mask8[NB-1:0];
    end

    // Alignment: an access must sit entirely inside one word at a natural boundary.
    always_comb begin
        case (size_e'(size_i))
            SZ_B:    misaligned_o = 1'b0;
            SZ_H:    misaligned_o = off3[0];
            SZ_W:    misaligned_o = (off3[1:0] != 2'b00);
            default: misaligned_o = (DATA_W == 32) ? 1'b1 : (off3 != 3'b000);
        endcase
    end

    // Load side: bring the addressed lanes down to bit 0, then sign/zero fill above.
    always_comb begin
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] sgn;
        logic [DATA_W-1:0] keep;
        logic              fill;
        int                bits;
        sh = rword_i >> {off_i, 3'b000};
        case (size_e'(size_i))
            SZ_B:    bits = 8;
            SZ_H:    bits = 16;
            SZ_W:    bits = 32;
            default: bits = DATA_W;
        endcase
        sgn       = sh >> (bits - 1);
        fill      = sgn[0] & ~ld_unsigned_i;
        keep      = {DATA_W{1'b1}} >> (DATA_W - bits);
        ld_data_o = (sh & keep) | ({DATA_W{fill}} & ~keep);
    end
endmodule

// File: rtl/sized_data_memory.sv
// Sized data memory: byte/half/word(/dword) loads and stores, zero-fill after reset.
// Latency: loads and fault flags appear one cycle after the request.
// ready=0 during the DEPTH-cycle zero-fill; requests then are dropped. Optional macro DMEM_WRITE_BYPASS_EN.
module sized_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    sized_data_memory_if.slave bus_if
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              init_we;

    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] word_idx_full;
    logic [IDX_W-1:0]  word_idx;
    logic [OFF_W-1:0]  offset;
    logic              out_of_range;
    logic              misaligned;
    logic              bad;
    logic              ready;
    logic              st_en;
    logic              ld_en;
    logic              req;

    logic [DATA_W-1:0] wdata_sh;
    logic [NB-1:0]     wmask;
    logic [DATA_W-1:0] wbits;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] ld_word;
    logic [DATA_W-1:0] ld_data;

    assign word_idx_full = bus_if.addr >> OFF_W;
    assign word_idx      = word_idx_full[IDX_W-1:0];
    assign offset        = bus_if.addr[OFF_W-1:0];
    assign out_of_range  = (word_idx_full >= ADDR_W'(DEPTH));
    assign ready         = (state_q == ST_RUN);
    assign bad           = misaligned | out_of_range;
    assign req           = ready & (bus_if.mem_read | bus_if.mem_write);
    assign st_en         = ready & bus_if.mem_write & ~bad;
    assign ld_en         = ready & bus_if.mem_read;

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i        (bus_if.size),
        .off_i         (offset),
        .ld_unsigned_i (bus_if.ld_unsigned),
        .wdata_i       (bus_if.write_data),
        .rword_i       (ld_word),
        .wdata_sh_o    (wdata_sh),
        .wmask_o       (wmask),
        .misaligned_o  (misaligned),
        .ld_data_o     (ld_data)
    );

    // Expand the byte mask to bits and form the post-store word.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            wbits[b*8 +: 8] = {8{wmask[b]}};
        end
        merged = (mem_q[word_idx] & ~wbits) | (wdata_sh & wbits);
    end

    // Load source word: pre-store (read-first) or merged (write-first).
    always_comb begin
`ifdef DMEM_WRITE_BYPASS_EN
        ld_word = st_en ? merged : mem_q[word_idx];
`else
        ld_word = mem_q[word_idx];
`endif
    end

    // Zero-fill sequencer: one word per cycle, then RUN until the next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: zero-fill during INIT, masked stores during RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we) begin
                mem_q[cnt_q] <= '0;
            end else if (st_en) begin
                mem_q[word_idx] <= merged;
            end
        end
    end

    // Next response: faulting loads return zero; read_data holds between loads.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = ld_en;
        fault_d      = req & bad;
        if (ld_en) begin
            read_data_d = bad ? '0 : ld_data;
        end
    end

    // Response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign bus_if.ready      = ready;
    assign bus_if.read_data  = read_data_q;
    assign bus_if.read_valid = read_valid_q;
    assign bus_if.fault      = fault_q;
endmodule

// File: tb/tb_sized_data_memory.sv
// Randomized bench for sized_data_memory against a byte-array reference model.
// Responses are checked one cycle after each request; inputs change on negedge.
// Reset/zero-fill timing and ignored requests during INIT are checked directly.
module tb_sized_data_memory;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NBYTE = DEPTH * 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sized_data_memory_if #(.DATA_W(DW), .ADDR_W(32)) bus ();

    sized_data_memory #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: memory as plain bytes, plus the expected response registers.
    logic [7:0]  mem_b [NBYTE];
    logic [31:0] exp_rdata;
    logic        exp_rv;
    logic        exp_fault;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        if (sz == 2'b11) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        if ((a / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        int          n;
        logic [63:0] v;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(mem_b[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) mem_b[a + i] = wd[8 * i +: 8];
    endtask

    task automatic set_idle();
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.size        = 2'b10;
        bus.ld_unsigned = 1'b0;
        bus.addr        = 32'd0;
        bus.write_data  = 32'd0;
    endtask

    task automatic check_outputs();
        check_eq("ready", 64'(bus.ready), 64'd1);
        check_eq("read_valid", 64'(bus.read_valid), 64'(exp_rv));
        check_eq("fault", 64'(bus.fault), 64'(exp_fault));
        check_eq("read_data", 64'(bus.read_data), 64'(exp_rdata));
    endtask

    // One request cycle: check the previous cycle's response, then present the next request.
    task automatic step(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
        bit bad;
        @(negedge clk);
        check_outputs();
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.size        = sz;
        bus.ld_unsigned = uns;
        bus.addr        = a;
        bus.write_data  = wd;
        bad       = is_bad(sz, a);
        exp_fault = (rd || wr) && bad;
        exp_rv    = rd;
`ifdef DMEM_WRITE_BYPASS_EN
        if (wr && !bad) model_store(sz, a, wd);
        if (rd) exp_rdata = bad ? 32'd0 : model_load(sz, uns, a);
`else
        if (rd) exp_rdata = bad ? 32'd0 : model_load(sz, uns, a);
        if (wr && !bad) model_store(sz, a, wd);
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    endtask

    // Reset, optionally re-pulsed part-way through the zero-fill, then time the fill.
    task automatic do_reset(input int abort_at);
        int n;
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        check_eq("rst_ready", 64'(bus.ready), 64'd0);
        check_eq("rst_read_valid", 64'(bus.read_valid), 64'd0);
        check_eq("rst_fault", 64'(bus.fault), 64'd0);
        check_eq("rst_read_data", 64'(bus.read_data), 64'd0);
        reset = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            check_eq("init_ready_mid", 64'(bus.ready), 64'd0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        // Requests during the fill must be ignored entirely.
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b1;
        bus.size       = 2'b10;
        bus.addr       = 32'h0000_0006;
        bus.write_data = 32'hFFFF_FFFF;
        n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
            if (n < 32) begin
                check_eq("init_read_valid", 64'(bus.read_valid), 64'd0);
                check_eq("init_fault", 64'(bus.fault), 64'd0);
            end
        end
        check_eq("init_cycles", 64'(n), 64'd32);
        set_idle();
        for (int i = 0; i < NBYTE; i++) mem_b[i] = 8'h00;
        exp_rdata = 32'd0;
        exp_rv    = 1'b0;
        exp_fault = 1'b0;
    endtask

    task automatic read_all();
        for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'd0);
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bit          rd, wr;
        reset = 1'b1;
        set_idle();
        exp_rdata = 32'd0;
        exp_rv    = 1'b0;
        exp_fault = 1'b0;
        repeat (2) @(posedge clk);

        do_reset(0);
        read_all();

        // Sized loads with sign/zero extension.
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_00FF);
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'd0);
        step(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
        step(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        idle();
        idle();

        // Misaligned and out-of-range requests.
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'd0);
        step(1'b0, 1'b1, 2'b01, 1'b0, 32'h05, 32'hBEEF);
        step(1'b1, 1'b0, 2'b11, 1'b0, 32'h08, 32'd0);
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFF0, 32'd0);
        idle();
        read_all();

        // Same-cycle load and store to one word.
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        step(1'b1, 1'b1, 2'b00, 1'b1, 32'h20, 32'h0000_00AA);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        idle();

        // Randomized back-to-back traffic.
        for (int i = 0; i < 600; i++) begin
            rd = ($urandom_range(0, 99) < 60);
            wr = ($urandom_range(0, 99) < 50);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = 32'($urandom_range(0, NBYTE + 15));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            step(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        idle();
        read_all();

        // Reset in RUN and part-way through INIT re-zero the memory.
        do_reset(0);
        read_all();
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678);
        idle();
        do_reset(10);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
